// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: opcode encodings, FSM states and decode helpers for the load/store unit
package lsu_ctrl_pkg;
  localparam int LSU_OPT_WIDTH = 4;
  localparam logic [3:0] LSU_LB  = 4'b0000;
  localparam logic [3:0] LSU_LH  = 4'b0010;
  localparam logic [3:0] LSU_LW  = 4'b0100;
  localparam logic [3:0] LSU_LBU = 4'b1000;
  localparam logic [3:0] LSU_LHU = 4'b1010;
  localparam logic [3:0] LSU_SB  = 4'b0001;
  localparam logic [3:0] LSU_SH  = 4'b0011;
  localparam logic [3:0] LSU_SW  = 4'b0101;
  localparam logic [3:0] LSU_NOP = 4'b1110;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  function automatic logic lsu_op_ok(input logic [3:0] opt);
    return opt inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW};
  endfunction
  function automatic logic lsu_misaligned(input logic [3:0] opt, input logic [1:0] a);
    return (opt[2:1] == 2'b01 && a[0]) || (opt[3:1] == 3'b010 && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: memory-side request/grant/response bus of the load/store unit
interface lsu_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, we, addr, wdata, wmask, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, wmask, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_ctrl_fmt.sv
// lsu_fmt: byte-lane formatting -- store mask, store data replication, load extract/extend
module lsu_fmt
  import lsu_ctrl_pkg::*;
(
  input  logic [LSU_OPT_WIDTH-1:0] opt,
  input  logic [1:0]               addr,
  input  logic [31:0]              wdata,
  input  logic [31:0]              rdata,
  output logic [3:0]               wmask,
  output logic [31:0]              wdata_rep,
  output logic [31:0]              rdata_fmt
);
  logic [2:0]  f3;
  logic [1:0]  hsel;
  logic [7:0]  b;
  logic [15:0] h;
  assign f3   = opt[3:1];
  assign hsel = {addr[1], 1'b0};
  assign b    = rdata[{addr, 3'b000} +: 8];
  assign h    = rdata[{hsel, 3'b000} +: 16];
  assign wmask = !opt[0]       ? 4'b0000 :
                 f3 == 3'b000  ? 4'b0001 << addr :
                 f3 == 3'b001  ? 4'b0011 << hsel :
                 f3 == 3'b010  ? 4'b1111 : 4'b0000;
  assign wdata_rep = f3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                     f3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign rdata_fmt = f3 == 3'b000 ? {{24{b[7]}}, b} :
                     f3 == 3'b001 ? {{16{h[15]}}, h} :
                     f3 == 3'b100 ? {24'b0, b} :
                     f3 == 3'b101 ? {16'b0, h} : rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller (IDLE/REQ/WAIT/DONE)
// LSU_MISALIGN_CHK_EN: when defined, misaligned half/word accesses complete without a memory request and pulse o_misalign
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [LSU_OPT_WIDTH-1:0] i_lsu_opt,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              i_wdata,
  lsu_ctrl_if.master               mem,
  output logic                     o_done,
  output logic [31:0]              o_rdata,
  output logic                     o_misalign
);
  state_e                   state, state_nx;
  logic [LSU_OPT_WIDTH-1:0] opt_q;
  logic [31:0]              addr_q, wdata_q, rdata_fmt;
  logic                     mis_q, acc, ok, mis;
  assign acc = i_valid & o_ready;
  assign ok  = lsu_op_ok(i_lsu_opt);
`ifdef LSU_MISALIGN_CHK_EN
  assign mis        = ok & lsu_misaligned(i_lsu_opt, i_addr[1:0]);
  assign o_misalign = mis_q & (state == DONE);
`else
  assign mis        = 1'b0;
  assign o_misalign = 1'b0;
`endif
  assign o_ready  = state == IDLE;
  assign o_done   = state == DONE;
  assign mem.req  = state == REQ;
  assign mem.we   = (state == REQ) & opt_q[0];
  assign mem.addr = {addr_q[31:2], 2'b00};
  lsu_fmt u_fmt (
    .opt       (opt_q),
    .addr      (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem.rdata),
    .wmask     (mem.wmask),
    .wdata_rep (mem.wdata),
    .rdata_fmt (rdata_fmt)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !acc ? IDLE : (ok && !mis) ? REQ : DONE;
      REQ:     state_nx = !mem.gnt ? REQ : opt_q[0] ? DONE : WAIT;
      WAIT:    state_nx = mem.rvalid ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      opt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      o_rdata <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        opt_q   <= i_lsu_opt;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        mis_q   <= mis;
        if (!ok) o_rdata <= '0;
`ifdef LSU_MISALIGN_CHK_EN
        if (mis) $display("lsu_ctrl misaligned access opt=%b addr=%h", i_lsu_opt, i_addr);
`endif
      end
      if (state == WAIT && mem.rvalid) o_rdata <= rdata_fmt;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plus randomized checks of lsu_ctrl against a transaction-level reference model
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready, o_done, o_misalign;
  logic [3:0]  i_lsu_opt = '0;
  logic [31:0] i_addr = '0, i_wdata = '0, o_rdata;
  logic [31:0] exp_rdata = '0;
  int          n_vec = 0, n_err = 0;
  lsu_ctrl_if mem();
  lsu_ctrl dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_lsu_opt  (i_lsu_opt),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .mem        (mem),
    .o_done     (o_done),
    .o_rdata    (o_rdata),
    .o_misalign (o_misalign)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model_load(input logic [3:0] opt, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] tb, th;
    tb = (d >> (8 * (a % 4))) & 32'hFF;
    th = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (opt)
      LSU_LB:  return tb >= 32'h80 ? tb - 32'h100 : tb;
      LSU_LH:  return th >= 32'h8000 ? th - 32'h10000 : th;
      LSU_LBU: return tb;
      LSU_LHU: return th;
      default: return d;
    endcase
  endfunction
  function automatic logic [31:0] model_mask(input logic [3:0] opt, input logic [31:0] a);
    case (opt)
      LSU_SB:  return 32'd1 << (a % 4);
      LSU_SH:  return 32'd3 << (2 * ((a / 2) % 2));
      default: return 32'd15;
    endcase
  endfunction
  function automatic logic [31:0] model_wdata(input logic [3:0] opt, input logic [31:0] wd);
    case (opt)
      LSU_SB:  return (wd & 32'hFF) * 32'h01010101;
      LSU_SH:  return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction
  task automatic do_op(input logic [3:0] opt, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int gd, input int rvd);
    int  f3;
    bit  st, ok, mis;
    f3  = int'(opt[3:1]);
    st  = opt[0];
    ok  = st ? (f3 <= 2) : (f3 inside {0, 1, 2, 4, 5});
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    mis = ok && (((f3 % 4) == 1 && addr % 2 == 1) || (f3 == 2 && addr % 4 != 0));
`endif
    chk("ready_idle", o_ready, 1);
    @(negedge i_clk);
    i_valid = 1'b1; i_lsu_opt = opt; i_addr = addr; i_wdata = wd;
    @(negedge i_clk);
    i_valid = 1'b0; i_lsu_opt = 4'($urandom); i_addr = $urandom; i_wdata = $urandom;
    if (!ok || mis) begin
      if (!ok) exp_rdata = '0;
      chk("short_req", mem.req, 0);
      chk("short_done", o_done, 1);
      chk("short_misalign", o_misalign, mis);
      chk("short_rdata", o_rdata, exp_rdata);
    end else begin
      for (int c = 0; c <= gd; c++) begin
        chk("req", mem.req, 1);
        chk("mem_addr", mem.addr, addr & ~32'd3);
        chk("we", mem.we, st);
        if (st) begin
          chk("wmask", mem.wmask, model_mask(opt, addr));
          chk("wdata", mem.wdata, model_wdata(opt, wd));
        end
        chk("done_req", o_done, 0);
        mem.gnt = (c == gd);
        mem.rvalid = (c == gd) ? 1'($urandom % 2) : 1'b0;
        mem.rdata = $urandom;
        @(negedge i_clk);
      end
      mem.gnt = 1'b0; mem.rvalid = 1'b0;
      if (!st) begin
        for (int c = 0; c <= rvd; c++) begin
          chk("req_wait", mem.req, 0);
          chk("done_wait", o_done, 0);
          mem.rvalid = (c == rvd);
          mem.rdata = (c == rvd) ? rd : $urandom;
          @(negedge i_clk);
        end
        mem.rvalid = 1'b0;
        exp_rdata = model_load(opt, addr, rd);
      end
      chk("done", o_done, 1);
      chk("rdata", o_rdata, exp_rdata);
      chk("misalign", o_misalign, 0);
    end
    @(negedge i_clk);
    chk("done_single", o_done, 0);
    chk("ready_back", o_ready, 1);
  endtask
  logic [3:0] ops [11];
  initial begin
    ops = '{LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW, LSU_NOP, 4'b0110, 4'b1001};
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
    #1;
    chk("rst_req", mem.req, 0);
    chk("rst_we", mem.we, 0);
    chk("rst_addr", mem.addr, 0);
    chk("rst_wdata", mem.wdata, 0);
    chk("rst_wmask", mem.wmask, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_misalign", o_misalign, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("rst_ready", o_ready, 1);
    do_op(LSU_SW,  32'h80000104, 32'hDEADBEEF, 32'h0, 0, 0);
    do_op(LSU_SB,  32'h80000003, 32'h000000A5, 32'h0, 0, 0);
    do_op(LSU_LB,  32'h80000002, 32'h0, 32'h12F45678, 0, 0);
    do_op(LSU_LBU, 32'h80000002, 32'h0, 32'h12F45678, 0, 0);
    do_op(LSU_LHU, 32'h80000002, 32'h0, 32'h12F45678, 0, 0);
    do_op(LSU_LW,  32'h80000010, 32'h0, 32'hCAFEF00D, 3, 2);
    do_op(LSU_LH,  32'h80000001, 32'h0, 32'h1234ABCD, 0, 0);
    do_op(LSU_SH,  32'h80000003, 32'h0000BEEF, 32'h0, 1, 0);
    do_op(LSU_NOP, 32'h80000020, 32'h0, 32'h0, 0, 0);
    // reset while a load sits in WAIT; a later rvalid must be ignored
    do_op(LSU_LW, 32'h80000040, 32'h0, 32'h55AA55AA, 0, 0);
    @(negedge i_clk);
    i_valid = 1'b1; i_lsu_opt = LSU_LW; i_addr = 32'h80000044;
    @(negedge i_clk);
    i_valid = 1'b0; mem.gnt = 1'b1;
    @(negedge i_clk);
    mem.gnt = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rstw_done", o_done, 0);
    chk("rstw_rdata", o_rdata, 0);
    chk("rstw_req", mem.req, 0);
    chk("rstw_ready", o_ready, 1);
    @(negedge i_clk);
    i_rst_n = 1'b1; mem.rvalid = 1'b1; mem.rdata = 32'h77777777;
    @(negedge i_clk);
    mem.rvalid = 1'b0;
    exp_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      chk("rstw_nodone", o_done, 0);
      chk("rstw_hold", o_rdata, 0);
      @(negedge i_clk);
    end
    for (int n = 0; n < 200; n++)
      do_op(ops[$urandom_range(10)], $urandom, $urandom, $urandom, $urandom_range(3), $urandom_range(3));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
